// File: rtl/branch_resolve_unit_pkg.sv
// Shared pipeline definitions for the ID-stage branch resolution logic.
//   brs_state_e : branch stall FSM encoding
//   FWD_*       : branch forwarding select encodings driven by the forwarding unit
package branch_resolve_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } brs_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/branch_operand_mux.sv
// Single-side forwarding mux for a branch compare operand.
//   sel        : forwarding select (00/11 regfile, 01 EX/MEM, 10 MEM/WB)
//   rf_data    : register file read data
//   exmem_data : EX/MEM ALU result
//   memwb_data : MEM/WB write-back value
//   operand    : selected compare operand
module branch_operand_mux
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = rf_data;
        unique case (sel)
            FWD_EXMEM: operand = exmem_data;
            FWD_MEMWB: operand = memwb_data;
            // Unused encoding 11 falls back to the register file, same as FWD_RF.
            default:   operand = rf_data;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: forwarded operand compare (beq/bne), target
// computation, pcSrc/flush generation, stall FSM for hazards forwarding cannot
// cover, and saturating branch/taken performance counters.
//   clk, rst                   : clock, synchronous active-high reset
//   IFID_*                     : branch instruction in ID
//   rsData, rtData             : register file read data
//   branchFWDA, branchFWDB     : forwarding selects per operand
//   EXMEM_aluOut, MEMWB_writeData : forwarded values
//   IDEX_*, EXMEM_*            : producer info for hazard detection
//   stall, pcSrc, flush        : pipeline control
//   branchTarget               : pc4 + (sext(imm) << 2)
//   branchCount, takenCount    : saturating performance counters
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned MAX_STALL = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IFID_valid,
    input  logic              IFID_isBranch,
    input  logic              IFID_bne,
    input  logic [DATA_W-1:0] IFID_pc4,
    input  logic [15:0]       IFID_imm,
    input  logic [REG_W-1:0]  IFID_rs,
    input  logic [REG_W-1:0]  IFID_rt,
    input  logic [DATA_W-1:0] rsData,
    input  logic [DATA_W-1:0] rtData,
    input  logic [1:0]        branchFWDA,
    input  logic [1:0]        branchFWDB,
    input  logic [DATA_W-1:0] EXMEM_aluOut,
    input  logic [DATA_W-1:0] MEMWB_writeData,
    input  logic [REG_W-1:0]  IDEX_rd,
    input  logic              IDEX_regWrite,
    input  logic              IDEX_memRead,
    input  logic [REG_W-1:0]  EXMEM_rd,
    input  logic              EXMEM_regWrite,
    input  logic              EXMEM_memRead,
    output logic              stall,
    output logic              pcSrc,
    output logic              flush,
    output logic [DATA_W-1:0] branchTarget,
    output logic [CNT_W-1:0]  branchCount,
    output logic [CNT_W-1:0]  takenCount
);

    localparam int unsigned STALL_W = $clog2(MAX_STALL + 1);

    brs_state_e         state_q, state_d;
    logic [STALL_W-1:0] cnt_q, cnt_d;
    logic [STALL_W-1:0] n_stall;
    logic [DATA_W-1:0]  op_a, op_b;
    logic [DATA_W-1:0]  imm_sext;
    logic               br, taken, resolve;

    function automatic logic reg_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt);
        return (r != '0) && ((r == rs) || (r == rt));
    endfunction

    assign br = IFID_valid & IFID_isBranch;

    branch_operand_mux #(.DATA_W(DATA_W)) u_mux_a (
        .sel        (branchFWDA),
        .rf_data    (rsData),
        .exmem_data (EXMEM_aluOut),
        .memwb_data (MEMWB_writeData),
        .operand    (op_a)
    );

    branch_operand_mux #(.DATA_W(DATA_W)) u_mux_b (
        .sel        (branchFWDB),
        .rf_data    (rtData),
        .exmem_data (EXMEM_aluOut),
        .memwb_data (MEMWB_writeData),
        .operand    (op_b)
    );

    assign taken        = (op_a == op_b) ^ IFID_bne;
    assign imm_sext     = {{(DATA_W-16){IFID_imm[15]}}, IFID_imm};
    assign branchTarget = IFID_pc4 + {imm_sext[DATA_W-3:0], 2'b00};

    // Load in EX needs two bubbles; ALU result in EX or load in MEM needs one.
    always_comb begin
        n_stall = '0;
        if (IDEX_regWrite && IDEX_memRead && reg_match(IDEX_rd, IFID_rs, IFID_rt)) begin
            n_stall = STALL_W'(2);
        end else if ((IDEX_regWrite && !IDEX_memRead && reg_match(IDEX_rd, IFID_rs, IFID_rt)) ||
                     (EXMEM_regWrite && EXMEM_memRead &&
                      reg_match(EXMEM_rd, IFID_rs, IFID_rt))) begin
            n_stall = STALL_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        resolve = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (br) begin
                        if (n_stall == '0) begin
                            resolve = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            cnt_d   = n_stall - STALL_W'(1);
                            state_d = (n_stall == STALL_W'(1)) ? RESOLVE : STALL;
                        end
                    end
                end
                STALL: begin
                    if (!IFID_valid) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q - STALL_W'(1);
                        if (cnt_q == STALL_W'(1)) state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    // Operands are not re-checked: the bubbles made forwarding valid.
                    state_d = IDLE;
                    resolve = IFID_valid;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pcSrc = resolve & taken;
    assign flush = pcSrc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            branchCount <= '0;
            takenCount  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (resolve && (branchCount != '1)) branchCount <= branchCount + CNT_W'(1);
            if (resolve && taken && (takenCount != '1)) takenCount <= takenCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        IFID_valid, IFID_isBranch, IFID_bne;
    logic [31:0] IFID_pc4;
    logic [15:0] IFID_imm;
    logic [4:0]  IFID_rs, IFID_rt;
    logic [31:0] rsData, rtData;
    logic [1:0]  branchFWDA, branchFWDB;
    logic [31:0] EXMEM_aluOut, MEMWB_writeData;
    logic [4:0]  IDEX_rd, EXMEM_rd;
    logic        IDEX_regWrite, IDEX_memRead, EXMEM_regWrite, EXMEM_memRead;
    logic        stall, pcSrc, flush;
    logic [31:0] branchTarget;
    logic [15:0] branchCount, takenCount;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk             (clk),
        .rst             (rst),
        .IFID_valid      (IFID_valid),
        .IFID_isBranch   (IFID_isBranch),
        .IFID_bne        (IFID_bne),
        .IFID_pc4        (IFID_pc4),
        .IFID_imm        (IFID_imm),
        .IFID_rs         (IFID_rs),
        .IFID_rt         (IFID_rt),
        .rsData          (rsData),
        .rtData          (rtData),
        .branchFWDA      (branchFWDA),
        .branchFWDB      (branchFWDB),
        .EXMEM_aluOut    (EXMEM_aluOut),
        .MEMWB_writeData (MEMWB_writeData),
        .IDEX_rd         (IDEX_rd),
        .IDEX_regWrite   (IDEX_regWrite),
        .IDEX_memRead    (IDEX_memRead),
        .EXMEM_rd        (EXMEM_rd),
        .EXMEM_regWrite  (EXMEM_regWrite),
        .EXMEM_memRead   (EXMEM_memRead),
        .stall           (stall),
        .pcSrc           (pcSrc),
        .flush           (flush),
        .branchTarget    (branchTarget),
        .branchCount     (branchCount),
        .takenCount      (takenCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the three control outputs in the current cycle.
    task automatic check_ctl(input string tag, input logic s, input logic p);
        check_eq({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
        check_eq({tag, ".pcSrc"}, {31'd0, pcSrc}, {31'd0, p});
        check_eq({tag, ".flush"}, {31'd0, flush}, {31'd0, p});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        IFID_valid = 0; IFID_isBranch = 0; IFID_bne = 0;
        IFID_pc4 = 32'h0; IFID_imm = 16'h0; IFID_rs = 0; IFID_rt = 0;
        rsData = 0; rtData = 0; branchFWDA = 2'b00; branchFWDB = 2'b00;
        EXMEM_aluOut = 0; MEMWB_writeData = 0;
        IDEX_rd = 0; IDEX_regWrite = 0; IDEX_memRead = 0;
        EXMEM_rd = 0; EXMEM_regWrite = 0; EXMEM_memRead = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic set_branch(input logic bne, input logic [4:0] rs, input logic [4:0] rt);
        IFID_valid = 1; IFID_isBranch = 1; IFID_bne = bne;
        IFID_rs = rs; IFID_rt = rt;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        next_cycle();
        // Reset wins over a resolvable taken beq.
        set_branch(0, 5'd0, 5'd0);
        sample();
        check_ctl("rst_force", 0, 0);
        next_cycle();
        check_eq("rst_bc", {16'd0, branchCount}, 32'd0);
        check_eq("rst_tc", {16'd0, takenCount}, 32'd0);
        rst = 0;
        clear_inputs();

        // 1: beq $0,$0, no hazard -> resolve same cycle, target 0x110.
        do_reset();
        set_branch(0, 5'd0, 5'd0);
        IFID_pc4 = 32'h100; IFID_imm = 16'h0004;
        sample();
        check_ctl("t1", 0, 1);
        check_eq("t1_target", branchTarget, 32'h110);
        next_cycle();
        clear_inputs();
        check_eq("t1_bc", {16'd0, branchCount}, 32'd1);
        check_eq("t1_tc", {16'd0, takenCount}, 32'd1);
        sample();
        check_ctl("t1_idle", 0, 0);

        // 2: bne after ALU producer in EX -> one stall, then not taken.
        do_reset();
        set_branch(1, 5'd5, 5'd6);
        IDEX_rd = 5'd5; IDEX_regWrite = 1;
        rsData = 32'd1; rtData = 32'd7;
        sample();
        check_ctl("t2_s0", 1, 0);
        next_cycle();
        IDEX_regWrite = 0; IDEX_rd = 0;
        branchFWDA = 2'b01; EXMEM_aluOut = 32'd7;
        sample();
        check_ctl("t2_res", 0, 0);
        next_cycle();
        clear_inputs();
        check_eq("t2_bc", {16'd0, branchCount}, 32'd1);
        check_eq("t2_tc", {16'd0, takenCount}, 32'd0);

        // 3: beq after load in EX -> two stalls (no early resolve), then taken via MEM/WB.
        do_reset();
        set_branch(0, 5'd8, 5'd9);
        IDEX_rd = 5'd9; IDEX_regWrite = 1; IDEX_memRead = 1;
        rsData = 32'h55; rtData = 32'h55;
        sample();
        check_ctl("t3_s0", 1, 0);
        next_cycle();
        IDEX_regWrite = 0; IDEX_memRead = 0; IDEX_rd = 0;
        sample();
        check_ctl("t3_s1", 1, 0);
        next_cycle();
        rtData = 32'h0; branchFWDB = 2'b10; MEMWB_writeData = 32'h55;
        sample();
        check_ctl("t3_res", 0, 1);
        next_cycle();
        clear_inputs();
        check_eq("t3_bc", {16'd0, branchCount}, 32'd1);
        check_eq("t3_tc", {16'd0, takenCount}, 32'd1);

        // 4: load in MEM feeding rs -> one stall, then taken via EX/MEM.
        do_reset();
        set_branch(0, 5'd3, 5'd4);
        EXMEM_rd = 5'd3; EXMEM_regWrite = 1; EXMEM_memRead = 1;
        rsData = 32'd1; rtData = 32'd2;
        sample();
        check_ctl("t4_s0", 1, 0);
        next_cycle();
        EXMEM_regWrite = 0; EXMEM_memRead = 0; EXMEM_rd = 0;
        branchFWDA = 2'b01; EXMEM_aluOut = 32'd2;
        sample();
        check_ctl("t4_res", 0, 1);
        next_cycle();
        clear_inputs();
        check_eq("t4_bc", {16'd0, branchCount}, 32'd1);

        // 5a: reset asserted in first stall cycle of a load hazard.
        do_reset();
        set_branch(0, 5'd0, 5'd9);
        IDEX_rd = 5'd9; IDEX_regWrite = 1; IDEX_memRead = 1;
        rst = 1;
        sample();
        check_ctl("t5a_rst", 0, 0);
        next_cycle();
        rst = 0;
        IDEX_regWrite = 0; IDEX_memRead = 0; IDEX_rd = 0;
        check_eq("t5a_bc", {16'd0, branchCount}, 32'd0);
        // Back in IDLE: a hazard-free taken branch resolves immediately.
        sample();
        check_ctl("t5a_idle", 0, 1);
        next_cycle();
        clear_inputs();

        // 5b: external squash during STALL -> no resolve, no count.
        do_reset();
        set_branch(0, 5'd0, 5'd9);
        IDEX_rd = 5'd9; IDEX_regWrite = 1; IDEX_memRead = 1;
        sample();
        check_ctl("t5b_s0", 1, 0);
        next_cycle();
        IDEX_regWrite = 0; IDEX_memRead = 0; IDEX_rd = 0;
        IFID_valid = 0;
        sample();
        check_ctl("t5b_abort", 0, 0);
        next_cycle();
        check_eq("t5b_bc", {16'd0, branchCount}, 32'd0);
        check_eq("t5b_tc", {16'd0, takenCount}, 32'd0);
        IFID_valid = 1;
        sample();
        check_ctl("t5b_idle", 0, 1);
        next_cycle();
        clear_inputs();

        // 7: select 11 falls back to regfile data.
        do_reset();
        set_branch(0, 5'd1, 5'd2);
        branchFWDA = 2'b11; rsData = 32'd5; rtData = 32'd5; EXMEM_aluOut = 32'd9;
        sample();
        check_ctl("t7_sel11", 0, 1);
        next_cycle();
        clear_inputs();

        // 6: counter saturation and negative immediate.
        do_reset();
        set_branch(0, 5'd0, 5'd0);
        for (int i = 0; i < 65535; i++) next_cycle();
        check_eq("t6_bc_full", {16'd0, branchCount}, 32'hFFFF);
        check_eq("t6_tc_full", {16'd0, takenCount}, 32'hFFFF);
        next_cycle();
        check_eq("t6_bc_sat", {16'd0, branchCount}, 32'hFFFF);
        check_eq("t6_tc_sat", {16'd0, takenCount}, 32'hFFFF);
        IFID_pc4 = 32'h0; IFID_imm = 16'hFFFF;
        sample();
        check_eq("t6_neg_target", branchTarget, 32'hFFFF_FFFC);
        next_cycle();
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
